// File: rtl/w_ctrl_pkg.sv
// Shared types and pointer helpers for the multi-port FIFO write/read controllers.
package w_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    STALL = 2'd2
  } w_state_e;

  localparam int PTR_MAX_W = 32;

  // Distance a - b on a w-bit wrapping pointer (w includes the wrap bit).
  function automatic logic [PTR_MAX_W-1:0] ptr_dist(
    input logic [PTR_MAX_W-1:0] a,
    input logic [PTR_MAX_W-1:0] b,
    input int unsigned          w
  );
    logic [PTR_MAX_W-1:0] mask;
    if (w >= PTR_MAX_W) mask = '1;
    else                mask = (PTR_MAX_W'(1) << w) - PTR_MAX_W'(1);
    return (a - b) & mask;
  endfunction

endpackage

// File: rtl/w_free_counter.sv
// Combinational free space and full flag from a write/read pointer pair.
module w_free_counter
  import w_ctrl_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic [AW:0] wr_ptr,
  input  logic [AW:0] rd_ptr,
  output logic [AW:0] free_cnt,
  output logic        full
);

  localparam logic [AW:0] DEPTH_V = {1'b1, {AW{1'b0}}};

  logic [AW:0] used;

  assign used     = (AW+1)'(ptr_dist(PTR_MAX_W'(wr_ptr), PTR_MAX_W'(rd_ptr), AW + 1));
  assign free_cnt = DEPTH_V - used;
  assign full     = (free_cnt == '0);

endmodule

// File: rtl/w_burst_controller.sv
// Write-side burst controller: up to PAR words per cycle into a DEPTH-entry FIFO.
// Optional partial acceptance is enabled by defining W_CTRL_PARTIAL_EN.
module w_burst_controller
  import w_ctrl_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PAR   = 2,
  parameter int AW    = $clog2(DEPTH),
  parameter int NW    = $clog2(PAR + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic [NW-1:0]     w_num,
  input  logic [AW:0]       rd_ptr,
  output logic [PAR-1:0]    wr_lane_en,
  output logic [PAR*AW-1:0] wr_addr,
  output logic [AW:0]       wr_ptr,
  output logic              ready,
  output logic [NW-1:0]     w_acc,
  output logic              full,
  output logic [AW:0]       free_cnt
);

  w_state_e       state_q, state_d;
  logic [NW-1:0]  cnt_q, cnt_d;
  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [PAR-1:0] lane_en_q, lane_en_d;
  logic           ready_q, ready_d;

  logic [NW-1:0]  n_req;
  logic [AW:0]    n_ext;
  logic [AW:0]    avail;

  w_free_counter #(
    .AW(AW)
  ) u_free (
    .wr_ptr  (wr_ptr_q),
    .rd_ptr  (rd_ptr),
    .free_cnt(free_cnt),
    .full    (full)
  );

  always_comb begin
    n_req = (w_num > NW'(PAR)) ? NW'(PAR) : w_num;
    n_ext = (AW+1)'(n_req);
    // In WRITE the pointer has not yet advanced, so discount the burst in flight.
    avail = (state_q == WRITE) ? (free_cnt - (AW+1)'(cnt_q)) : free_cnt;

    state_d = IDLE;
    cnt_d   = '0;
    if (w_en && (n_req != '0)) begin
      if (n_ext <= avail) begin
        state_d = WRITE;
        cnt_d   = n_req;
      end
`ifdef W_CTRL_PARTIAL_EN
      else if (avail != '0) begin
        state_d = WRITE;
        cnt_d   = NW'(avail);
      end
`endif
      else begin
        state_d = STALL;
      end
    end

    wr_ptr_d = wr_ptr_q;
    if (state_q == WRITE) wr_ptr_d = wr_ptr_q + (AW+1)'(cnt_q);

    ready_d   = (state_d == WRITE);
    lane_en_d = '0;
    for (int i = 0; i < PAR; i++) begin
      lane_en_d[i] = (NW'(i) < cnt_d);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      lane_en_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      lane_en_q <= lane_en_d;
      ready_q   <= ready_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < PAR; gi++) begin : g_lane_addr
      assign wr_addr[gi*AW +: AW] = wr_ptr_q[AW-1:0] + AW'(gi);
    end
  endgenerate

  assign wr_lane_en = lane_en_q;
  assign wr_ptr     = wr_ptr_q;
  assign ready      = ready_q;
  assign w_acc      = cnt_q;

endmodule

// File: tb/tb_w_burst_controller.sv
// Directed scoreboard bench for w_burst_controller at DEPTH=16, PAR=2.
module tb_w_burst_controller;

  localparam int DEPTH = 16;
  localparam int PAR   = 2;
  localparam int AW    = 4;
  localparam int NW    = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              w_en = 1'b0;
  logic [NW-1:0]     w_num = '0;
  logic [AW:0]       rd_ptr = '0;
  logic [PAR-1:0]    wr_lane_en;
  logic [PAR*AW-1:0] wr_addr;
  logic [AW:0]       wr_ptr;
  logic              ready;
  logic [NW-1:0]     w_acc;
  logic              full;
  logic [AW:0]       free_cnt;

  typedef struct {
    logic [PAR-1:0]    lane;
    logic [PAR*AW-1:0] addr;
    logic [NW-1:0]     acc;
  } exp_t;

  exp_t sb[$];
  int   checks    = 0;
  int   failures  = 0;
  int   model_ptr = 0;

  w_burst_controller #(
    .DEPTH(DEPTH),
    .PAR  (PAR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .w_en      (w_en),
    .w_num     (w_num),
    .rd_ptr    (rd_ptr),
    .wr_lane_en(wr_lane_en),
    .wr_addr   (wr_addr),
    .wr_ptr    (wr_ptr),
    .ready     (ready),
    .w_acc     (w_acc),
    .full      (full),
    .free_cnt  (free_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int num);
    exp_t e;
    int   n;
    n      = (num > PAR) ? PAR : num;
    e.lane = (n == 2) ? 2'b11 : 2'b01;
    e.addr = {AW'((model_ptr + 1) % DEPTH), AW'(model_ptr % DEPTH)};
    e.acc  = NW'(n);
    sb.push_back(e);
    model_ptr = (model_ptr + n) % (2 * DEPTH);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    checks++;
    assert (sb.size() > 0)
    else begin
      failures++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_ready"}, 32'(ready), 32'd1);
      chk({tag, "_lane"}, 32'(wr_lane_en), 32'(e.lane));
      chk({tag, "_addr"}, 32'(wr_addr), 32'(e.addr));
      chk({tag, "_acc"}, 32'(w_acc), 32'(e.acc));
      $display("burst %s lane=%b addr=%h acc=%0d wr_ptr=%0d", tag, wr_lane_en, wr_addr, w_acc, wr_ptr);
    end
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int k;
    k = 0;
    do begin
      cyc();
      k++;
    end while (ready !== 1'b1 && k < budget);
    chk({tag, "_timeout"}, 32'(ready), 32'd1);
  endtask

  initial begin
    // Reset state
    repeat (3) cyc();
    rst = 1'b1;
    cyc();
    chk("rst_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("rst_lane", 32'(wr_lane_en), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_acc", 32'(w_acc), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_free", 32'(free_cnt), 32'd16);
    chk("rst_addr", 32'(wr_addr), 32'h10);

    // Single burst into an empty FIFO
    w_en = 1'b1; w_num = 2'd2; push_exp(2);
    wait_ready("single", 8);
    pop_cmp("single");
    w_en = 1'b0;
    cyc();
    chk("single_wr_ptr", 32'(wr_ptr), 32'd2);
    chk("single_free", 32'(free_cnt), 32'd14);
    chk("single_idle", 32'(ready), 32'd0);

    // Asynchronous reset during a WRITE cycle
    w_en = 1'b1; push_exp(2);
    wait_ready("prerst", 8);
    pop_cmp("prerst");
    rst = 1'b0; w_en = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(ready), 32'd0);
    chk("mid_rst_lane", 32'(wr_lane_en), 32'd0);
    chk("mid_rst_acc", 32'(w_acc), 32'd0);
    chk("mid_rst_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("mid_rst_free", 32'(free_cnt), 32'd16);
    cyc();
    rst = 1'b1; model_ptr = 0;
    cyc();

    // Eight back-to-back bursts fill the FIFO, ninth request stalls
    w_en = 1'b1; w_num = 2'd2;
    for (int i = 0; i < 8; i++) push_exp(2);
    wait_ready("fill0", 8);
    pop_cmp("fill0");
    for (int i = 1; i < 8; i++) begin
      cyc();
      pop_cmp($sformatf("fill%0d", i));
    end
    cyc();
    chk("fill_stall_ready", 32'(ready), 32'd0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_wr_ptr", 32'(wr_ptr), 32'h10);
    chk("fill_free", 32'(free_cnt), 32'd0);
    cyc();
    chk("stall_hold_ready", 32'(ready), 32'd0);

    // Reader frees two entries; stalled request writes at wrapped addresses
    rd_ptr = 5'd2; push_exp(2);
    cyc();
    pop_cmp("release");
    w_en = 1'b0;
    cyc();
    chk("release_wr_ptr", 32'(wr_ptr), 32'h12);
    chk("release_full", 32'(full), 32'd1);
    chk("release_idle", 32'(ready), 32'd0);

    // Burst that crosses address 15 -> 0
    rst = 1'b0;
    #1;
    cyc();
    rst = 1'b1; rd_ptr = '0; model_ptr = 0;
    cyc();
    w_en = 1'b1; w_num = 2'd1; push_exp(1);
    wait_ready("one", 8);
    pop_cmp("one");
    w_en = 1'b0;
    cyc();
    chk("one_wr_ptr", 32'(wr_ptr), 32'd1);
    rd_ptr = 5'd1;
    w_en = 1'b1; w_num = 2'd2;
    for (int i = 0; i < 8; i++) push_exp(2);
    wait_ready("wrap0", 8);
    pop_cmp("wrap0");
    for (int i = 1; i < 8; i++) begin
      cyc();
      pop_cmp($sformatf("wrap%0d", i));
    end
    chk("wrap_cross_addr", 32'(wr_addr), 32'h0f);
    cyc();
    chk("wrap_stall_ready", 32'(ready), 32'd0);
    chk("wrap_wr_ptr", 32'(wr_ptr), 32'd17);
    chk("wrap_full", 32'(full), 32'd1);
    w_en = 1'b0;

    // One free entry, two words requested
    rd_ptr = 5'd2;
    cyc();
    chk("free1", 32'(free_cnt), 32'd1);
    w_en = 1'b1; w_num = 2'd2;
`ifdef W_CTRL_PARTIAL_EN
    push_exp(1);
    cyc();
    pop_cmp("partial");
    w_en = 1'b0;
    cyc();
    chk("partial_wr_ptr", 32'(wr_ptr), 32'd18);
    chk("partial_full", 32'(full), 32'd1);
`else
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("nopartial_stall%0d", i), 32'(ready), 32'd0);
      chk($sformatf("nopartial_lane%0d", i), 32'(wr_lane_en), 32'd0);
    end
    chk("nopartial_wr_ptr", 32'(wr_ptr), 32'd17);
    w_en = 1'b0;
    cyc();
`endif

    // Oversized w_num is clamped to PAR
    rd_ptr = 5'(model_ptr);
    cyc();
    chk("clamp_free", 32'(free_cnt), 32'd16);
    w_en = 1'b1; w_num = 2'd3; push_exp(3);
    wait_ready("clamp", 8);
    pop_cmp("clamp");
    w_en = 1'b0;
    cyc();
    chk("clamp_wr_ptr", 32'(wr_ptr), 32'(model_ptr));
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/w_burst_controller.md
# w_burst_controller

Parametrised write-side controller for the team's multi-port FIFO. It accepts write requests of up to PAR words per cycle and owns the write pointer. It drives per-lane load enables and wrapped addresses into the FIFO storage, and computes full and free space from the read pointer. Compared with the single-shot write controller, it adds configurable depth and lane count, back-to-back bursts, an explicit stall state and optional partial acceptance.

## Interface
- DEPTH, 16, FIFO entries; power of two, at least 4
- PAR, 2, write lanes per cycle; 1 ≤ PAR ≤ DEPTH/2
- AW, $clog2(DEPTH), address width (derived; do not override)
- NW, $clog2(PAR+1), width of w_num and w_acc (derived)
- clk  in  1  single clock; all state on the rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- w_en  in  1  write request; held until accepted
- w_num  in  NW  words offered this request; values above PAR are clamped to PAR
- rd_ptr  in  AW+1  read pointer from the read controller, same clock domain, wrap bit is the MSB
- wr_lane_en  out  PAR  per-lane load enables (successor of ld1/ld2)
- wr_addr  out  PAR*AW  lane i address in bits [i*AW +: AW]
- wr_ptr  out  AW+1  registered write pointer, wrap bit is the MSB
- ready  out  1  acceptance pulse; high for exactly the cycles a burst is written
- w_acc  out  NW  words accepted in the current WRITE cycle; 0 otherwise
- full  out  1  free_cnt == 0
- free_cnt  out  AW+1  DEPTH − (wr_ptr − rd_ptr) mod 2^(AW+1)

## Operation
- Moore FSM with three states: IDLE, WRITE, STALL.
- Request count: n = min(w_num, PAR). A request with w_en=1 and n=0 is ignored and the FSM stays in IDLE.
- Next-state rules from IDLE or STALL:
  - w_en=0 → IDLE.
  - n ≤ free_cnt → WRITE.
  - Otherwise → STALL.
- Next-state rules from WRITE use post-write space, free_cnt − cnt_q:
  - w_en=1 and n ≤ that value → WRITE.
  - w_en=1, n > that value → STALL.
  - Else → IDLE.
- cnt_q captures the accepted count on every transition into WRITE.
- In WRITE:
  - wr_lane_en[i] = (i < cnt_q).
  - ready=1, w_acc=cnt_q.
  - wr_ptr += cnt_q at the closing edge.
- In IDLE and STALL: wr_lane_en=0, ready=0, w_acc=0.
- Addresses: lane i = (wr_ptr[AW-1:0] + i) mod DEPTH, combinational from wr_ptr. Addresses wrap through 0 within a single burst.
- Pointer arithmetic is AW+1 bits, modulo 2^(AW+1). Empty is wr_ptr == rd_ptr; full is a difference of DEPTH.
- Simultaneous read and write: the stale rd_ptr is used for the decision, which is conservative. Freed space is seen the cycle after rd_ptr changes.
- Reset asserted mid-burst: state goes to IDLE immediately and asynchronously. The in-flight burst is discarded and wr_ptr returns to 0.

## Timing
- Reset values: state IDLE, wr_ptr=0, wr_lane_en=0, ready=0, w_acc=0, full=0, free_cnt=DEPTH. wr_addr lane i = i.
- Latency: a request sampled at edge k with space available produces WRITE outputs during cycle k+1. The updated wr_ptr is visible from k+2.
- Handshake:
  - The requester holds w_en and w_num stable until it sees ready=1.
  - w_en still high at the edge closing a ready cycle is a new request. The requester deasserts w_en in the ready cycle if no further data is pending.
- Throughput: one burst per cycle while space allows. Each STALL costs whole cycles until space appears.
- full and free_cnt are combinational from registered wr_ptr and the rd_ptr input.

## Configuration
- W_CTRL_PARTIAL_EN defined:
  - From IDLE, STALL or WRITE, a request with n > available space but space > 0 goes to WRITE.
  - It accepts min(n, space) words; w_acc reports that count.
  - The requester retires w_acc words and re-requests the rest.
  - STALL is entered only when space == 0.
- Not defined: all-or-nothing acceptance. w_acc is always cnt_q == n or 0.

## Structure
- Package w_ctrl_pkg holds:
  - the state typedef: IDLE=2'd0, WRITE=2'd1, STALL=2'd2;
  - the pointer-distance function used for free_cnt.
- Sub-module w_free_counter: combinational free_cnt and full from wr_ptr and rd_ptr, parametrised on AW. It is reused by the read-side successor.

## Test plan
All scenarios use DEPTH=16 and PAR=2.
- rst=0 during a WRITE cycle → outputs immediately at reset values; wr_ptr=0, free_cnt=16.
- Empty FIFO, w_en=1, w_num=2 → next cycle wr_lane_en=2'b11, addresses {1,0}, ready=1, w_acc=2; then wr_ptr=2, free_cnt=14.
- w_en held with w_num=2 for 8 bursts, rd_ptr=0 → 8 consecutive ready cycles, then full=1, wr_ptr=5'b10000. A 9th request → STALL, ready=0.
- From that full stall, rd_ptr set to 2 → WRITE on the following cycle at addresses {1,0} (wrap), then wr_ptr=5'b10010.
- wr_ptr=15, rd_ptr=1, w_num=2 → lanes at addresses {0,15}, crossing the wrap.
- free_cnt=1, w_num=2:
  - without W_CTRL_PARTIAL_EN → STALL;
  - with it → wr_lane_en=2'b01, w_acc=1.
- w_num=3 → clamped; wr_lane_en=2'b11, w_acc=2.
